// File: rtl/alu_adder_hold.sv
// alu_adder_hold: registers the inverted ALU result, applies BCD adjust, holds add and flags.
// Define ALU_ADDER_HOLD_DECIMAL_FLAGS_EN to derive N/Z from the adjusted value in decimal mode.
module alu_adder_hold #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk_2,
   input  logic             res_n,
   input  logic             load,
   input  logic [WIDTH-1:0] result_n,
   input  logic             half_carry,
   input  logic             alu_cout_n,
   input  logic             overflow_n,
   input  logic             daa_n,
   input  logic             dsa_n,
   output logic [WIDTH-1:0] add,
   output logic             c_out,
   output logic             v_out,
   output logic             n_out,
   output logic             z_out,
   output logic             valid,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, ADJUST, DONE} state_t;
   state_t state, state_nxt;
   logic [WIDTH-1:0] raw, raw_q, adj, nz_src;
   logic [3:0] lo, hi;
   logic h_q, c_q, v_q, sub_q, accept, bin;
   assign raw    = ~result_n;
   assign accept = load && state != ADJUST;
   assign bin    = daa_n && dsa_n;
   assign valid  = state == DONE;
   assign busy   = state == ADJUST;
   // nibbles wrap independently; -6 mod 16 is 4'ha
   assign lo  = raw_q[3:0] + (sub_q ? (h_q ? 4'h0 : 4'ha) : (h_q ? 4'h6 : 4'h0));
   assign hi  = raw_q[7:4] + (sub_q ? (c_q ? 4'h0 : 4'ha) : (c_q ? 4'h6 : 4'h0));
   assign adj = {hi, lo};
`ifdef ALU_ADDER_HOLD_DECIMAL_FLAGS_EN
   assign nz_src = adj;
`else
   assign nz_src = raw_q;
`endif
   always_comb begin
      state_nxt = state;
      if (state == ADJUST) state_nxt = DONE;
      else if (accept) state_nxt = bin ? DONE : ADJUST;
      else if (state == DONE) state_nxt = IDLE;
   end
   always_ff @(posedge clk_2 or negedge res_n)
      if (!res_n) state <= IDLE;
      else state <= state_nxt;
   always_ff @(posedge clk_2 or negedge res_n) begin
      if (!res_n) begin
         add   <= RESET_VALUE;
         c_out <= 1'b0;
         v_out <= 1'b0;
         n_out <= 1'b0;
         z_out <= 1'b0;
         raw_q <= '0;
         h_q   <= 1'b0;
         c_q   <= 1'b0;
         v_q   <= 1'b0;
         sub_q <= 1'b0;
      end else if (state == ADJUST) begin
         add   <= adj;
         c_out <= c_q;
         v_out <= v_q;
         n_out <= nz_src[WIDTH-1];
         z_out <= nz_src == '0;
      end else if (accept && bin) begin
         add   <= raw;
         c_out <= ~alu_cout_n;
         v_out <= ~overflow_n;
         n_out <= raw[WIDTH-1];
         z_out <= raw == '0;
      end else if (accept) begin
         raw_q <= raw;
         h_q   <= half_carry;
         c_q   <= ~alu_cout_n;
         v_q   <= ~overflow_n;
         sub_q <= daa_n;
      end
   end
endmodule
